// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch stage: owns the fetch PC, issues fixed-latency reads
// to instruction memory and buffers returned {pc, instr} pairs for decode.
module fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   imem_valid,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [DATA_W-1:0]      inst_out,
  output logic [ADDR_W-1:0]      inst_pc,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] LP_DEPTH = (PTR_W+2)'(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;

  logic             w_nonempty;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W+1:0] w_reserved;

  // A slot is reserved for the in-flight read, so a response can never find the FIFO full.
  assign w_reserved = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_issue    = reset && !redirect && (w_reserved < LP_DEPTH);
  assign w_nonempty = (r_count != '0);
  assign w_push     = r_inflight && imem_valid && !redirect;
  assign w_pop      = inst_valid && inst_ready;

  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = w_nonempty && !redirect;
  assign inst_out   = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
  assign inst_pc    = w_nonempty ? r_pc_mem[r_rd_ptr]   : '0;
  assign occupancy  = r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the empty-gated read mux hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
      r_data_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model, 1-cycle memory
// responder, directed timing scenarios and a randomized ready/redirect phase.
module tb_fetch_queue;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              imem_valid = 1'b0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Reference model: the FIFO as a queue plus the single outstanding read.
  entry_t            m_q[$];
  logic [ADDR_W-1:0] m_fetch_pc;
  bit                m_inflight;
  logic [ADDR_W-1:0] m_inflight_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_req    = 0;

  bit                prev_req = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit                unsol_en = 1'b0;
  logic [ADDR_W-1:0] next_deliver = '0;

  bit                obs_req;
  logic [ADDR_W-1:0] obs_addr;
  bit                obs_valid;
  logic [ADDR_W-1:0] obs_pc;
  logic [DATA_W-1:0] obs_out;
  logic [OCC_W-1:0]  obs_occ;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle, entered and left at a falling edge: drive, settle, compare, advance model.
  task automatic step(input bit rdy, input bit redir, input logic [ADDR_W-1:0] rpc);
    bit exp_req;
    bit exp_valid;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_valid  = prev_req;
    imem_rdata  = prev_req ? mem_word(prev_addr) : '0;
    if (!prev_req && unsol_en && ($urandom_range(0, 3) == 0)) begin
      imem_valid = 1'b1;
      imem_rdata = 16'hDEAD;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    obs_out   = inst_out;
    obs_occ   = occupancy;
    if (obs_req) n_req++;

    exp_req   = !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
    exp_valid = !redir && (m_q.size() > 0);
    check("imem_req", obs_req, exp_req);
    if (exp_req) check("imem_addr", obs_addr, m_fetch_pc);
    check("inst_valid", obs_valid, exp_valid);
    if (exp_valid) begin
      check("inst_pc", obs_pc, m_q[0].pc);
      check("inst_out", obs_out, m_q[0].data);
    end
    check("occupancy", obs_occ, m_q.size());

    // Delivered stream must be consecutive addresses with matching memory contents.
    if (obs_valid && rdy) begin
      check("deliver_pc", obs_pc, next_deliver);
      check("deliver_data", obs_out, mem_word(next_deliver));
      next_deliver = next_deliver + 1'b1;
    end

    if (redir) begin
      m_q.delete();
      m_inflight   = 1'b0;
      m_fetch_pc   = rpc;
      next_deliver = rpc;
    end else begin
      if (exp_valid && rdy) void'(m_q.pop_front());
      if (m_inflight && imem_valid) m_q.push_back({m_inflight_pc, imem_rdata});
      m_inflight = exp_req;
      if (exp_req) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 1'b1;
      end
    end
    prev_req  = obs_req;
    prev_addr = obs_addr;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_occupancy", occupancy, 0);
    m_q.delete();
    m_inflight    = 1'b0;
    m_fetch_pc    = '0;
    m_inflight_pc = '0;
    prev_req      = 1'b0;
    next_deliver  = '0;
    inst_ready    = 1'b0;
    redirect      = 1'b0;
    imem_valid    = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Release reset and pin the 2-cycle startup latency with literal expectations.
  task automatic release_and_check(input bit rdy);
    reset = 1'b1;
    step(rdy, 1'b0, '0);
    check("c0_req", obs_req, 1);
    check("c0_addr", obs_addr, 16'h0000);
    step(rdy, 1'b0, '0);
    check("c1_valid", obs_valid, 0);
    step(rdy, 1'b0, '0);
    check("c2_valid", obs_valid, 1);
    check("c2_pc", obs_pc, 16'h0000);
    check("c2_out", obs_out, 16'hA000);
  endtask

  initial begin
    logic [ADDR_W-1:0] wrap_exp [4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    @(negedge clk);
    pulse_reset();

    // Streaming with ready held high: one instruction per cycle.
    release_and_check(1'b1);
    for (int c = 3; c < 12; c++) begin
      step(1'b1, 1'b0, '0);
      check("stream_valid", obs_valid, 1);
      check("stream_pc", obs_pc, c - 2);
      check("stream_out", obs_out, 16'hA000 + c - 2);
    end

    // Mid-stream reset, then ready low: fill to DEPTH and stop requesting.
    pulse_reset();
    n_req = 0;
    release_and_check(1'b0);
    repeat (6) step(1'b0, 1'b0, '0);
    check("full_requests", n_req, 4);
    check("full_occupancy", obs_occ, 4);
    check("full_req_off", obs_req, 0);
    repeat (12) step(1'b1, 1'b0, '0);
    check("drain_delivered", next_deliver, 12);

    // Redirect with a partly full FIFO and a response in flight, then back-to-back redirects.
    pulse_reset();
    release_and_check(1'b1);
    repeat (3) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0040);
    check("r6_valid", obs_valid, 0);
    check("r6_req", obs_req, 0);
    check("r6_occ", obs_occ, 1);
    step(1'b1, 1'b0, '0);
    check("r7_occ", obs_occ, 0);
    check("r7_req", obs_req, 1);
    check("r7_addr", obs_addr, 16'h0040);
    step(1'b1, 1'b0, '0);
    check("r8_valid", obs_valid, 0);
    step(1'b1, 1'b0, '0);
    check("r9_valid", obs_valid, 1);
    check("r9_pc", obs_pc, 16'h0040);
    check("r9_out", obs_out, 16'hA040);
    step(1'b1, 1'b1, 16'h0100);
    step(1'b1, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, '0);
    check("r12_addr", obs_addr, 16'hFFFE);
    step(1'b1, 1'b0, '0);
    check("r13_valid", obs_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      check("wrap_valid", obs_valid, 1);
      check("wrap_pc", obs_pc, wrap_exp[k]);
    end

    // Random ready, occasional redirects, unsolicited memory strobes.
    pulse_reset();
    release_and_check(1'b1);
    unsol_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 49) == 0)
        step(1'($urandom_range(0, 1)), 1'b1, 16'($urandom()));
      else
        step(1'($urandom_range(0, 1)), 1'b0, '0);
    end
    unsol_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
